// File: rtl/c13_prod_accum_pkg.sv
// Shared types and constants for the c13 product accumulator.
// Optional macro SATURATE_EN (see c13_acc_add) selects saturating accumulation.
package c13_pkg;

    localparam int PROD_W    = 8;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    // Width of the drain beat index; never below one bit.
    function automatic int beat_w(input int acc_w);
        return (acc_w / 8 > 1) ? $clog2(acc_w / 8) : 1;
    endfunction

endpackage

// File: rtl/c13_prod_accum_if.sv
// Product-in / byte-stream-out bundle between the multiplier side and the accumulator.
interface c13_prod_accum_if #(
    parameter int CNT_W = c13_pkg::CNT_W_DEF
);
    import c13_pkg::*;

    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              prod_ready;
    logic              clear;
    logic              rd_req;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic [CNT_W-1:0]  acc_count;
    logic              ovf;

    modport master (
        output prod, prod_valid, clear, rd_req,
        input  prod_ready, out_byte, out_valid, out_last, busy, acc_count, ovf
    );

    modport slave (
        input  prod, prod_valid, clear, rd_req,
        output prod_ready, out_byte, out_valid, out_last, busy, acc_count, ovf
    );

endinterface

// File: rtl/c13_acc_add.sv
// Accumulator adder: acc + zero-extended product with carry-out.
// SATURATE_EN defined: an overflowing sum clamps to all-ones; otherwise it wraps.
module c13_acc_add
    import c13_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc_next,
    output logic              carry
);

    logic [ACC_W:0] sum;

    assign sum   = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign carry = sum[ACC_W];

`ifdef SATURATE_EN
    assign acc_next = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/c13_prod_accum.sv
// Multiply-accumulate back end: sums products, snapshots on rd_req, drains LSB byte first.
// Build with SATURATE_EN defined for a saturating accumulator.
module c13_prod_accum
    import c13_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    c13_prod_accum_if.slave bus
);

    localparam int NB     = ACC_W / 8;
    localparam int BEAT_W = beat_w(ACC_W);

    logic [ACC_W-1:0]  acc, snap, add_sum, acc_sum;
    logic [CNT_W-1:0]  count;
    logic              ovf, carry, accept, start, last_beat;
    state_t            state, state_next;
    logic [BEAT_W-1:0] beat, beat_next;
    logic [7:0]        byte_q, byte_next;
    logic              valid_q, valid_next, last_q, last_next, busy_q, busy_next;

    assign bus.prod_ready = ~bus.clear;
    assign accept         = bus.prod_valid & ~bus.clear;

    c13_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc      (acc),
        .prod     (bus.prod),
        .acc_next (add_sum),
        .carry    (carry)
    );

    // Value acc would take this edge; the snapshot must include a same-edge accept.
    assign acc_sum   = accept ? add_sum : acc;
    assign last_beat = (state == DRAIN) && (beat == BEAT_W'(NB - 1));
    assign start     = bus.rd_req && ((state == IDLE) || last_beat);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        byte_next  = '0;
        valid_next = 1'b0;
        last_next  = 1'b0;
        busy_next  = 1'b0;
        if (start) begin
            state_next = DRAIN;
            beat_next  = '0;
            byte_next  = acc_sum[7:0];
            valid_next = 1'b1;
            last_next  = (NB == 1);
            busy_next  = 1'b1;
        end else if (state == DRAIN) begin
            if (last_beat) begin
                state_next = IDLE;
            end else begin
                beat_next  = beat + 1'b1;
                byte_next  = snap[8*int'(beat_next) +: 8];
                valid_next = 1'b1;
                last_next  = (beat_next == BEAT_W'(NB - 1));
                busy_next  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_next;
            beat    <= beat_next;
            byte_q  <= byte_next;
            valid_q <= valid_next;
            last_q  <= last_next;
            busy_q  <= busy_next;
        end
    end

    // Snapshot wins over clear, which wins over an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            snap  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (start) begin
            snap  <= acc_sum;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.clear) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc <= add_sum;
            if (count != '1) count <= count + 1'b1;
            if (carry) ovf <= 1'b1;
        end
    end

    assign bus.out_byte  = byte_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.acc_count = count;
    assign bus.ovf       = ovf;

endmodule
